// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state codes, opcodes, ALUOp codes and control word for the multicycle MIPS controller
package mips_ctrl_pkg;
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_ILLEGAL = 4'd12,
        S_BUSERR  = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_en;
        logic       illegal;
        logic       bus_err;
    } ctrl_t;
endpackage

// File: rtl/mips_ctrl_outdec.sv
// mips_ctrl_outdec: combinational state-to-control-word decode
// Ports: state, mem_ready, zero in; ctrl out. JUMP decode built only with MIPS_CTRL_JUMP_EN.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    input  logic   zero,
    output ctrl_t  ctrl
);
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.alu_src_b = 2'b01;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_en     = mem_ready;
            end
            S_DECODE:  ctrl.alu_src_b = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
            end
            S_MEMRD:   ctrl.iord = 1'b1;
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_src    = 2'b01;
                ctrl.pc_en     = zero;
            end
            S_ADDIWB:  ctrl.reg_write = 1'b1;
`ifdef MIPS_CTRL_JUMP_EN
            S_JUMP: begin
                ctrl.pc_src = 2'b10;
                ctrl.pc_en  = 1'b1;
            end
`endif
            S_ILLEGAL: ctrl.illegal = 1'b1;
            S_BUSERR:  ctrl.bus_err = 1'b1;
            default:   ctrl = '0;
        endcase
    end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS main control FSM with MemReady handshake and bus timeout
// Ports: clk, reset (async high), Opcode, Zero, MemReady in; datapath controls, Illegal, BusErr, State out.
// Option: MIPS_CTRL_JUMP_EN enables the j instruction (JUMP state).
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       Illegal,
    output logic       BusErr,
    output logic [3:0] State
);
    localparam int CW = $clog2(TIMEOUT + 1);
    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic timed_out;
    ctrl_t dec, ctrl;
    // the wait that ends this cycle is the TIMEOUT-th one
    assign timed_out = !MemReady && cnt >= CW'(TIMEOUT - 1);
    always_comb begin
        nxt = S_FETCH;
        case (state)
            S_FETCH:   nxt = MemReady ? S_DECODE : timed_out ? S_BUSERR : S_FETCH;
            S_DECODE:
                case (Opcode)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_RTYPE:     nxt = S_EXECUTE;
                    OP_BEQ:       nxt = S_BRANCH;
                    OP_ADDI:      nxt = S_ADDIEX;
`ifdef MIPS_CTRL_JUMP_EN
                    OP_J:         nxt = S_JUMP;
`endif
                    default:      nxt = S_ILLEGAL;
                endcase
            S_MEMADR:  nxt = Opcode == OP_SW ? S_MEMWR : S_MEMRD;
            S_MEMRD:   nxt = MemReady ? S_MEMWB : timed_out ? S_BUSERR : S_MEMRD;
            S_MEMWR:   nxt = MemReady ? S_FETCH : timed_out ? S_BUSERR : S_MEMWR;
            S_EXECUTE: nxt = S_ALUWB;
            S_ADDIEX:  nxt = S_ADDIWB;
            default:   nxt = S_FETCH;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
            cnt   <= '0;
        end else begin
            state <= nxt;
            cnt   <= nxt != state ? '0 : (!MemReady && cnt != CW'(TIMEOUT)) ? cnt + 1'b1 : cnt;
        end
    end
    mips_ctrl_outdec u_outdec (
        .state     (state),
        .mem_ready (MemReady),
        .zero      (Zero),
        .ctrl      (dec)
    );
    // reset is asynchronous, so FETCH decode must be masked while it is held
    assign ctrl     = reset ? '0 : dec;
    assign IorD     = ctrl.iord;
    assign MemWrite = ctrl.mem_write;
    assign IRWrite  = ctrl.ir_write;
    assign RegDst   = ctrl.reg_dst;
    assign MemtoReg = ctrl.mem_to_reg;
    assign RegWrite = ctrl.reg_write;
    assign ALUSrcA  = ctrl.alu_src_a;
    assign ALUSrcB  = ctrl.alu_src_b;
    assign ALUOp    = ctrl.alu_op;
    assign PCSrc    = ctrl.pc_src;
    assign PCEn     = ctrl.pc_en;
    assign Illegal  = ctrl.illegal;
    assign BusErr   = ctrl.bus_err;
    assign State    = state;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] Opcode = 6'b0;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b1;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn, Illegal, BusErr;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic [3:0] State;
    int total = 0;
    int bad = 0;

    mips_multicycle_ctrl #(.TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn), .Illegal(Illegal), .BusErr(BusErr),
        .State(State)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] all_out();
        return {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn, Illegal, BusErr};
    endfunction

    initial begin
        #1;
        check("reset_outs", all_out(), 0);
        check("reset_state", 32'(State), 0);
        step();
        check("reset_outs_clk", all_out(), 0);
        reset = 1'b0;
        #1;
        // R-type
        check("rt_fetch_state", 32'(State), 0);
        check("rt_fetch_irw", 32'({IRWrite, PCEn, ALUSrcB, IorD, ALUSrcA}), 32'b11_01_00);
        step();
        check("rt_decode", 32'({State, ALUSrcB, ALUOp}), {4'd1, 2'b11, 2'b00});
        step();
        check("rt_exec", 32'({State, ALUSrcA, ALUSrcB, ALUOp}), {4'd6, 1'b1, 2'b00, 2'b10});
        step();
        check("rt_aluwb", 32'({State, RegWrite, RegDst}), {4'd7, 2'b11});
        step();
        check("rt_back", 32'(State), 0);
        // lw with 3 wait cycles
        Opcode = 6'b100011;
        step();
        check("lw_decode", 32'(State), 1);
        step();
        check("lw_memadr", 32'({State, ALUSrcA, ALUSrcB, ALUOp}), {4'd2, 1'b1, 2'b10, 2'b00});
        step();
        MemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("lw_memrd_wait", 32'({State, IorD, RegWrite}), {4'd3, 2'b10});
            step();
        end
        MemReady = 1'b1;
        #1;
        check("lw_memrd_ready", 32'({State, IorD}), {4'd3, 1'b1});
        step();
        check("lw_memwb", 32'({State, MemtoReg, RegWrite, RegDst}), {4'd4, 3'b110});
        step();
        check("lw_back", 32'(State), 0);
        // beq
        Opcode = 6'b000100;
        step();
        step();
        Zero = 1'b1;
        #1;
        check("beq_taken", 32'({State, PCEn, PCSrc, ALUOp, ALUSrcA}), {4'd8, 1'b1, 2'b01, 2'b01, 1'b1});
        Zero = 1'b0;
        #1;
        check("beq_not_taken", 32'({PCEn, PCSrc}), {1'b0, 2'b01});
        step();
        check("beq_back", 32'(State), 0);
        // addi
        Opcode = 6'b001000;
        step();
        step();
        check("addi_ex", 32'({State, ALUSrcA, ALUSrcB, ALUOp}), {4'd9, 1'b1, 2'b10, 2'b00});
        step();
        check("addi_wb", 32'({State, RegWrite, RegDst, MemtoReg}), {4'd10, 3'b100});
        step();
        check("addi_back", 32'(State), 0);
        // sw with MemReady stuck low -> bus timeout
        Opcode = 6'b101011;
        step();
        step();
        check("sw_memadr", 32'(State), 2);
        step();
        MemReady = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #1;
            check("sw_memwr_wait", 32'({State, MemWrite, IorD, RegWrite}), {4'd5, 3'b110});
            step();
        end
        check("sw_buserr", 32'({State, BusErr, RegWrite, MemWrite}), {4'd13, 3'b100});
        MemReady = 1'b1;
        step();
        check("sw_after_buserr", 32'({State, BusErr}), {4'd0, 1'b0});
        // j
        Opcode = 6'b000010;
        step();
        step();
`ifdef MIPS_CTRL_JUMP_EN
        check("j_jump", 32'({State, PCEn, PCSrc}), {4'd11, 1'b1, 2'b10});
`else
        check("j_illegal", 32'({State, Illegal, PCEn, PCSrc}), {4'd12, 1'b1, 1'b0, 2'b00});
`endif
        step();
        check("j_back", 32'({State, Illegal}), {4'd0, 1'b0});
        // undefined opcode
        Opcode = 6'b111111;
        step();
        step();
        check("bad_op_illegal", 32'({State, Illegal, PCEn}), {4'd12, 2'b10});
        step();
        check("bad_op_back", 32'(State), 0);
        // reset during MEMWR
        Opcode = 6'b101011;
        step();
        step();
        step();
        MemReady = 1'b0;
        #1;
        check("rst_pre_memwr", 32'({State, MemWrite}), {4'd5, 1'b1});
        reset = 1'b1;
        #1;
        check("rst_memwrite_drop", 32'(MemWrite), 0);
        check("rst_outs_zero", all_out(), 0);
        check("rst_state", 32'(State), 0);
        step();
        reset = 1'b0;
        MemReady = 1'b1;
        #1;
        check("rst_release_state", 32'(State), 0);
        check("rst_release_irw", 32'({IRWrite, PCEn}), 2'b11);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
